mul_addsub_pipe: RTL and testbench
==================================

// Module: mul_addsub_pipe
// PURPOSE
//   Pipelined signed multiply-then-add/subtract unit: out = in1*in2 +/- addend, addend = in3 or internal accumulator.
//   Sequential successor to the combinational multiplier/adder pair; valid/ready on both sides, full throughput.
//   Sits in the differentiator datapath (coefficient*exponent, term accumulation).
// PARAMETERS
//   IN_WIDTH    8   signed width of in1/in2
//   GUARD       4   extra accumulator bits above product width
//   ACC_WIDTH   2*IN_WIDTH+GUARD  (derived localparam) width of in3/out/accumulator
//   COUNT_WIDTH 16  width of op_count
// PORTS
//   clk       in   1            rising-edge clock
//   rst_n     in   1            asynchronous active-low reset
//   in_valid  in   1            operand set valid
//   in_ready  out  1            unit accepts operands this cycle
//   in1       in   IN_WIDTH     signed multiplicand
//   in2       in   IN_WIDTH     signed multiplier
//   in3       in   ACC_WIDTH    signed addend (ignored when acc_en=1)
//   add_sub   in   1            0: product+addend, 1: product-addend
//   acc_en    in   1            1: addend = accumulator; result written back to accumulator
//   acc_clr   in   1            with acc_en: accumulator treated as 0 for this op
//   out_valid out  1            result valid
//   out_ready in   1            downstream accepts result
//   out       out  ACC_WIDTH    signed result
//   out_ovf   out  1            result overflowed ACC_WIDTH (wrapped or clamped)
//   done      out  1            out_valid & out_ready (result consumed this cycle)
//   op_count  out  COUNT_WIDTH  number of results consumed, wraps at 2^COUNT_WIDTH
// BEHAVIOUR
//   - Clock/reset: one clock clk; reset is asynchronous and active-low (rst_n).
//   - Reset: all stage valids, out, out_ovf, accumulator, op_count = 0; in_ready forced 0 while rst_n=0.
//   - Reset mid-operation: in-flight ops discarded, no done pulse, accumulator cleared.
//   - Stage S1: on in_valid&in_ready register product = in1*in2 (2*IN_WIDTH signed), add_sub, acc_en, acc_clr, in3.
//   - Stage S2: sign-extend product to ACC_WIDTH; addend = acc_en ? (acc_clr ? 0 : acc) : in3;
//     compute in ACC_WIDTH+1 bits; out_ovf = top two bits differ; out = low ACC_WIDTH bits (or clamped).
//   - Accumulator updated with out only when an acc_en op loads S2; back-to-back acc ops chain without bubbles.
//   - Latency: 2 cycles from accepted input to out_valid; throughput 1 op/cycle while out_ready=1.
//   - Ready chain (combinational): s2_rdy = !s2_v | out_ready; s1_rdy = !s1_v | s2_rdy; in_ready = s1_rdy.
//   - Backpressure: out_ready=0 holds out/out_ovf stable; pipeline fills (2 ops) then in_ready=0.
//   - Simultaneous accept + output drain in one cycle: both occur, no bubble, no loss.
//   - done/op_count: done combinational; op_count += 1 on done, wraps to 0 from all-ones.
//   - in1/in2 = -2^(IN_WIDTH-1) both: product = +2^(2*IN_WIDTH-2), exact, no overflow.
// CONFIGURATION
//   MUL_ADDSUB_SAT_EN defined: on overflow out clamps to +(2^(ACC_WIDTH-1)-1) or -2^(ACC_WIDTH-1)
//     by sign of the true sum; accumulator stores clamped value; out_ovf still asserted.
//   Undefined: two's-complement wrap; out_ovf asserted; accumulator stores wrapped value.
// STRUCTURE
//   Package arith_pkg: localparams OP_ADD=1'b0, OP_SUB=1'b1; functions sat_max(w), sat_min(w).
//   One sub-module addsub_sat (S2 combinational add/sub, overflow detect, macro-controlled clamp);
//   pipeline registers, accumulator, counter in top.
// TESTING  (IN_WIDTH=8, GUARD=4 -> ACC_WIDTH=20)
//   1. in1=7,in2=-3,in3=5,add_sub=0, out_ready=1 -> out=-16 two cycles later, out_ovf=0, done=1, op_count=1.
//   2. Same operands add_sub=1 streamed 8 back-to-back -> out=-26 on 8 consecutive cycles, op_count=8, in_ready stays 1.
//   3. out_ready=0, push 3 ops -> first two accepted, in_ready=0 on third until out_ready=1; results in order, none lost.
//   4. acc_en=1, first op acc_clr=1, in1=in2=-128 x32 back-to-back -> outs 16384,32768..., 32nd out_ovf=1:
//      out=-524288 (wrap) or 524287 with MUL_ADDSUB_SAT_EN.
//   5. Assert rst_n low with 2 ops in flight -> out_valid=0, op_count=0, accumulator 0, no done; next acc op starts from 0.
//   6. op_count at 16'hFFFF, one done -> op_count=0.

Source files
------------

// File: rtl/arith_pkg.sv
// ============================================================================
// | Package     : arith_pkg                                                  |
// | Description : Shared add/sub opcodes and saturation bound helpers for    |
// |               the multiply-add/subtract pipeline.                        |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
`default_nettype none

package arith_pkg;

  // Operation select carried on add_sub
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // Largest positive w-bit two's-complement value, zero-extended to 64 bits
  function automatic logic [63:0] sat_max(input int w);
    return (64'd1 << (w - 1)) - 64'd1;
  endfunction

  // Most negative w-bit two's-complement value; only the low w bits are meaningful
  function automatic logic [63:0] sat_min(input int w);
    return ~sat_max(w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/addsub_sat.sv
// ============================================================================
// | Module      : addsub_sat                                                 |
// | Description : Second-stage combinational add/subtract of a sign-extended |
// |               product and an addend, with overflow detection. When       |
// |               MUL_ADDSUB_SAT_EN is defined the result clamps to the      |
// |               signed range on overflow, otherwise it wraps.              |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
`default_nettype none

module addsub_sat
  import arith_pkg::*;
#(
  parameter int PROD_WIDTH = 16,
  parameter int ACC_WIDTH  = 20
) (
  input  logic [PROD_WIDTH-1:0] i_prod,
  input  logic [ACC_WIDTH-1:0]  i_addend,
  input  logic                  i_sub,
  output logic [ACC_WIDTH-1:0]  o_sum,
  output logic                  o_ovf
);

  // One extra bit so the true sum is always representable
  localparam int SUM_WIDTH = ACC_WIDTH + 1;

  logic [SUM_WIDTH-1:0] w_prod_ext;
  logic [SUM_WIDTH-1:0] w_add_ext;
  logic [SUM_WIDTH-1:0] w_sum_full;
  logic                 w_ovf;

  assign w_prod_ext = {{(SUM_WIDTH-PROD_WIDTH){i_prod[PROD_WIDTH-1]}}, i_prod};
  assign w_add_ext  = {i_addend[ACC_WIDTH-1], i_addend};
  assign w_sum_full = (i_sub == OP_SUB) ? (w_prod_ext - w_add_ext)
                                        : (w_prod_ext + w_add_ext);

  // Top two bits disagree exactly when the sum leaves the ACC_WIDTH range
  assign w_ovf = w_sum_full[SUM_WIDTH-1] ^ w_sum_full[SUM_WIDTH-2];
  assign o_ovf = w_ovf;

`ifdef MUL_ADDSUB_SAT_EN
  localparam logic [63:0]          c_sat_max_full = sat_max(ACC_WIDTH);
  localparam logic [63:0]          c_sat_min_full = sat_min(ACC_WIDTH);
  localparam logic [ACC_WIDTH-1:0] c_sat_max      = c_sat_max_full[ACC_WIDTH-1:0];
  localparam logic [ACC_WIDTH-1:0] c_sat_min      = c_sat_min_full[ACC_WIDTH-1:0];

  // Clamp toward the sign of the true (wide) sum on overflow
  always_comb begin
    o_sum = w_sum_full[ACC_WIDTH-1:0];
    if (w_ovf) begin
      o_sum = w_sum_full[SUM_WIDTH-1] ? c_sat_min : c_sat_max;
    end
  end
`else
  // Two's-complement wrap: simply drop the extra top bit
  assign o_sum = w_sum_full[ACC_WIDTH-1:0];
`endif

endmodule

`default_nettype wire

// File: rtl/mul_addsub_pipe.sv
// ============================================================================
// | Module      : mul_addsub_pipe                                            |
// | Description : Two-stage pipelined signed multiply then add/subtract.     |
// |               S1 registers the product, S2 adds/subtracts in3 or the     |
// |               internal accumulator. Valid/ready on both sides with a     |
// |               combinational ready chain for full throughput.             |
// |               Config macro: MUL_ADDSUB_SAT_EN (clamp instead of wrap).   |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
`default_nettype none

module mul_addsub_pipe
  import arith_pkg::*;
#(
  parameter int IN_WIDTH    = 8,
  parameter int GUARD       = 4,
  parameter int COUNT_WIDTH = 16
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [IN_WIDTH-1:0]           in1,
  input  logic [IN_WIDTH-1:0]           in2,
  input  logic [2*IN_WIDTH+GUARD-1:0]   in3,
  input  logic                          add_sub,
  input  logic                          acc_en,
  input  logic                          acc_clr,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [2*IN_WIDTH+GUARD-1:0]   out,
  output logic                          out_ovf,
  output logic                          done,
  output logic [COUNT_WIDTH-1:0]        op_count
);

  localparam int PROD_WIDTH = 2 * IN_WIDTH;
  localparam int ACC_WIDTH  = 2 * IN_WIDTH + GUARD;

  // Stage 1 registers
  logic                  r_s1_v;
  logic [PROD_WIDTH-1:0] r_s1_prod;
  logic                  r_s1_sub;
  logic                  r_s1_acc_en;
  logic                  r_s1_acc_clr;
  logic [ACC_WIDTH-1:0]  r_s1_in3;

  // Stage 2 / output registers
  logic                   r_s2_v;
  logic [ACC_WIDTH-1:0]   r_out;
  logic                   r_ovf;
  logic [ACC_WIDTH-1:0]   r_acc;
  logic [COUNT_WIDTH-1:0] r_count;

  logic                        w_s2_rdy;
  logic                        w_s1_rdy;
  logic                        w_accept;
  logic                        w_s2_load;
  logic                        w_done;
  logic signed [PROD_WIDTH-1:0] w_prod;
  logic [ACC_WIDTH-1:0]        w_addend;
  logic [ACC_WIDTH-1:0]        w_sum;
  logic                        w_ovf;

  // Ready chain: a stage can take new data if it is empty or draining this cycle
  assign w_s2_rdy  = !r_s2_v || out_ready;
  assign w_s1_rdy  = !r_s1_v || w_s2_rdy;
  assign in_ready  = rst_n && w_s1_rdy;
  assign w_accept  = in_valid && in_ready;
  assign w_s2_load = r_s1_v && w_s2_rdy;
  assign w_done    = r_s2_v && out_ready;

  // Full-precision signed product; -2^(N-1) squared still fits in 2N bits
  assign w_prod = $signed(in1) * $signed(in2);

  // Accumulator is read at the moment the op moves into S2, so chained acc ops need no bubble
  assign w_addend = r_s1_acc_en ? (r_s1_acc_clr ? '0 : r_acc) : r_s1_in3;

  addsub_sat #(
    .PROD_WIDTH (PROD_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_addsub_sat (
    .i_prod   (r_s1_prod),
    .i_addend (w_addend),
    .i_sub    (r_s1_sub),
    .o_sum    (w_sum),
    .o_ovf    (w_ovf)
  );

  // Stage 1: capture product and control whenever S1 is free to advance
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_v       <= 1'b0;
      r_s1_prod    <= '0;
      r_s1_sub     <= OP_ADD;
      r_s1_acc_en  <= 1'b0;
      r_s1_acc_clr <= 1'b0;
      r_s1_in3     <= '0;
    end else if (w_s1_rdy) begin
      r_s1_v <= w_accept;
      if (w_accept) begin
        r_s1_prod    <= w_prod;
        r_s1_sub     <= add_sub;
        r_s1_acc_en  <= acc_en;
        r_s1_acc_clr <= acc_clr;
        r_s1_in3     <= in3;
      end
    end
  end

  // Stage 2: register result and overflow flag; hold them while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s2_v <= 1'b0;
      r_out  <= '0;
      r_ovf  <= 1'b0;
    end else if (w_s2_rdy) begin
      r_s2_v <= r_s1_v;
      if (r_s1_v) begin
        r_out <= w_sum;
        r_ovf <= w_ovf;
      end
    end
  end

  // Accumulator write-back only for acc ops entering S2
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (w_s2_load && r_s1_acc_en) begin
      r_acc <= w_sum;
    end
  end

  // Count consumed results, wrapping naturally at the counter width
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (w_done) begin
      r_count <= r_count + COUNT_WIDTH'(1);
    end
  end

  assign out_valid = r_s2_v;
  assign out       = r_out;
  assign out_ovf   = r_ovf;
  assign done      = w_done;
  assign op_count  = r_count;

endmodule

`default_nettype wire

// File: tb/tb_mul_addsub_pipe.sv
// ============================================================================
// | Module      : tb_mul_addsub_pipe                                         |
// | Description : Self-checking bench for mul_addsub_pipe (IN_WIDTH=8,       |
// |               GUARD=4). Integer reference model plus scoreboard queue.   |
// |               Honours MUL_ADDSUB_SAT_EN for expected overflow results.   |
// | Revision    : 1.0 - initial release                                      |
// ============================================================================
`default_nettype none

module tb_mul_addsub_pipe;

  localparam longint MAXV = 524287;
  localparam longint MINV = -524288;
  localparam longint SPAN = 1048576;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in1;
  logic [7:0]  in2;
  logic [19:0] in3;
  logic        add_sub;
  logic        acc_en;
  logic        acc_clr;
  logic        out_valid;
  logic        out_ready;
  logic [19:0] out;
  logic        out_ovf;
  logic        done;
  logic [15:0] op_count;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [20:0] q[$];
  longint      m_acc  = 0;
  logic [15:0] m_cnt  = 0;
  int          n_acc  = 0;
  int          n_done = 0;

  mul_addsub_pipe #(
    .IN_WIDTH    (8),
    .GUARD       (4),
    .COUNT_WIDTH (16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .add_sub   (add_sub),
    .acc_en    (acc_en),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_ovf   (out_ovf),
    .done      (done),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    q.delete();
    m_acc  = 0;
    m_cnt  = 0;
    n_acc  = 0;
    n_done = 0;
  endtask

  // One clock: model accepted op, score consumed result, then check the counter
  task automatic cycle();
    longint p, ad, s, r;
    logic   ov;
    logic [20:0] e;
    #1;
    if (in_valid && in_ready) begin
      p  = longint'($signed(in1)) * longint'($signed(in2));
      ad = acc_en ? (acc_clr ? 64'sd0 : m_acc) : longint'($signed(in3));
      s  = add_sub ? (p - ad) : (p + ad);
      ov = (s > MAXV) || (s < MINV);
`ifdef MUL_ADDSUB_SAT_EN
      r = (s > MAXV) ? MAXV : ((s < MINV) ? MINV : s);
`else
      r = (s - MINV) % SPAN;
      if (r < 0) r = r + SPAN;
      r = r + MINV;
`endif
      if (acc_en) m_acc = r;
      q.push_back({ov, 20'(r)});
      n_acc++;
    end
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("sb_unexpected", 32'd1, 32'd0);
      end else begin
        e = q.pop_front();
        chk("sb_out", 32'(out), 32'(e[19:0]));
        chk("sb_ovf", 32'(out_ovf), 32'(e[20]));
      end
      m_cnt = m_cnt + 16'd1;
      n_done++;
    end
    @(posedge clk);
    #1;
    chk("op_count", 32'(op_count), 32'(m_cnt));
  endtask

  task automatic set_op(input logic [7:0] a, input logic [7:0] b, input logic [19:0] c,
                        input logic sub, input logic ae, input logic clr);
    in1 = a; in2 = b; in3 = c; add_sub = sub; acc_en = ae; acc_clr = clr;
  endtask

  initial begin
    int k;
    logic [19:0] last_exp;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    set_op(8'd0, 8'd0, 20'd0, 1'b0, 1'b0, 1'b0);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out", 32'(out), 32'd0);
    chk("rst_ovf", 32'(out_ovf), 32'd0);
    chk("rst_count", 32'(op_count), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("rst_rel_ready", 32'(in_ready), 32'd1);

    // 7 * -3 + 5 = -16, two-cycle latency
    set_op(8'd7, 8'hFD, 20'd5, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    chk("t1_lat1", 32'(out_valid), 32'd0);
    cycle();
    chk("t1_valid", 32'(out_valid), 32'd1);
    chk("t1_out", 32'(out), 32'(20'hFFFF0));
    chk("t1_ovf", 32'(out_ovf), 32'd0);
    chk("t1_done", 32'(done), 32'd1);
    cycle();
    chk("t1_count", 32'(op_count), 32'd1);

    // 8 back-to-back subtracts: 7 * -3 - 5 = -26
    set_op(8'd7, 8'hFD, 20'd5, 1'b1, 1'b0, 1'b0);
    k = 0;
    for (int i = 0; i < 11; i++) begin
      in_valid = (i < 8);
      #1;
      if (i < 8) chk("t2_ready", 32'(in_ready), 32'd1);
      if (out_valid) begin
        k++;
        chk("t2_out", 32'(out), 32'(20'hFFFE6));
      end
      cycle();
    end
    chk("t2_nout", 32'(k), 32'd8);
    chk("t2_count", 32'(op_count), 32'd9);

    // Backpressure: two ops fill the pipe, third waits
    out_ready = 1'b0;
    set_op(8'd3, 8'd4, 20'd1, 1'b0, 1'b0, 1'b0);
    in_valid = 1'b1;
    #1; chk("t3_rdy_a", 32'(in_ready), 32'd1);
    cycle();
    set_op(8'd5, 8'd6, 20'd2, 1'b1, 1'b0, 1'b0);
    #1; chk("t3_rdy_b", 32'(in_ready), 32'd1);
    cycle();
    set_op(8'hF0, 8'd9, 20'd100, 1'b0, 1'b0, 1'b0);
    #1; chk("t3_rdy_c0", 32'(in_ready), 32'd0);
    cycle();
    #1; chk("t3_rdy_c1", 32'(in_ready), 32'd0);
    chk("t3_hold", 32'(out), 32'(q[0][19:0]));
    cycle();
    chk("t3_hold2", 32'(out), 32'(q[0][19:0]));
    out_ready = 1'b1;
    #1; chk("t3_rdy_rel", 32'(in_ready), 32'd1);
    cycle();
    in_valid = 1'b0;
    repeat (4) cycle();
    chk("t3_drained", 32'(q.size()), 32'd0);

    // Accumulate -128 * -128 thirty-two times, wrapping/clamping on the last
`ifdef MUL_ADDSUB_SAT_EN
    last_exp = 20'h7FFFF;
`else
    last_exp = 20'h80000;
`endif
    k = 0;
    for (int i = 0; i < 35; i++) begin
      in_valid = (i < 32);
      set_op(8'h80, 8'h80, 20'd0, 1'b0, 1'b1, (i == 0));
      #1;
      if (out_valid) begin
        k++;
        if (k == 1) chk("t4_first", 32'(out), 32'd16384);
        if (k == 2) chk("t4_second", 32'(out), 32'd32768);
        if (k == 31) chk("t4_ovf31", 32'(out_ovf), 32'd0);
        if (k == 32) begin
          chk("t4_last", 32'(out), 32'(last_exp));
          chk("t4_last_ovf", 32'(out_ovf), 32'd1);
        end
      end
      cycle();
    end
    chk("t4_nout", 32'(k), 32'd32);

    // Randomized mix with random backpressure
    for (int i = 0; i < 400; i++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      set_op(8'($urandom), 8'($urandom),
             ($urandom_range(0, 1) != 0) ? 20'($urandom) : 20'($urandom_range(0, 2000)),
             1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             ($urandom_range(0, 7) == 0));
      cycle();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cycle();
    chk("rand_drained", 32'(q.size()), 32'd0);

    // Reset with two acc ops in flight
    out_ready = 1'b0;
    set_op(8'd50, 8'd50, 20'd0, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b1;
    cycle();
    cycle();
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst_n = 1'b0;
    #1;
    chk("t5_valid", 32'(out_valid), 32'd0);
    chk("t5_done", 32'(done), 32'd0);
    chk("t5_count", 32'(op_count), 32'd0);
    chk("t5_ready", 32'(in_ready), 32'd0);
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    set_op(8'd2, 8'd3, 20'd0, 1'b0, 1'b1, 1'b0);
    in_valid = 1'b1;
    cycle();
    in_valid = 1'b0;
    cycle();
    chk("t5_acc_valid", 32'(out_valid), 32'd1);
    chk("t5_acc_out", 32'(out), 32'd6);
    cycle();

    // Counter wrap: reach 0xFFFF consumed results, then one more
    rst_n = 1'b0;
    #1;
    model_clear();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 70000 && n_done < 65535; i++) begin
      in_valid = (n_acc < 65536);
      set_op(8'($urandom), 8'($urandom), 20'($urandom_range(0, 1000)), 1'b0, 1'b0, 1'b0);
      cycle();
    end
    in_valid = 1'b0;
    chk("t6_reached", 32'(n_done), 32'd65535);
    chk("t6_ffff", 32'(op_count), 32'h0000FFFF);
    chk("t6_pending", 32'(done), 32'd1);
    cycle();
    chk("t6_wrap", 32'(op_count), 32'd0);
    repeat (3) cycle();
    chk("t6_drained", 32'(q.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
